// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction NOP encoding, IF-stage FSM states, reset defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int              WORD_ADDR_W_DEF  = 30;
  localparam int              WORD_DATA_W_DEF  = 32;
  localparam logic [29:0]     RESET_VECTOR_DEF = 30'h0;

  // Encoding loaded into IF/ID whenever the entry is a bubble.
  localparam logic [31:0]     ISA_NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_KILL,
    ST_HOLD
  } if_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-bus read channel between the fetch stage (master) and instruction memory (slave).
// Latency: a beat completes in the cycle rdy is high while req is high; req/addr are held until then.
// Backpressure: memory stretches a beat by holding rdy low; the master never withdraws a request.
// Signals: req/addr (master->slave), rd_data/rdy (slave->master).
interface if_stage_if
  import cpu_pkg::*;
#(
  parameter int WORD_ADDR_W = WORD_ADDR_W_DEF,
  parameter int WORD_DATA_W = WORD_DATA_W_DEF
) ();

  logic                   req;
  logic [WORD_ADDR_W-1:0] addr;
  logic [WORD_DATA_W-1:0] rd_data;
  logic                   rdy;

  modport master (output req, output addr, input rd_data, input rdy);
  modport slave  (input req, input addr, output rd_data, output rdy);

endinterface

// File: rtl/if_reg.sv
// IF/ID pipeline register: loads a fetched instruction, inserts bubbles, holds under stall, clears on flush.
// Latency: 1 cycle from ld_* to if_*.
// Backpressure: stall freezes the entry; flush overrides stall.
// Ports: clk, reset_ (sync, active-high), stall, flush, ld_en/ld_pc/ld_insn in; if_pc/if_insn/if_en out.
module if_reg
  import cpu_pkg::*;
#(
  parameter int WORD_ADDR_W = WORD_ADDR_W_DEF,
  parameter int WORD_DATA_W = WORD_DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   ld_en,
  input  logic [WORD_ADDR_W-1:0] ld_pc,
  input  logic [WORD_DATA_W-1:0] ld_insn,
  output logic [WORD_ADDR_W-1:0] if_pc,
  output logic [WORD_DATA_W-1:0] if_insn,
  output logic                   if_en
);

  localparam logic [WORD_DATA_W-1:0] NOP = WORD_DATA_W'(ISA_NOP);

  always_ff @(posedge clk) begin
    if (reset_) begin
      if_pc   <= '0;
      if_insn <= NOP;
      if_en   <= 1'b0;
    end else if (flush) begin
      if_insn <= NOP;
      if_en   <= 1'b0;
    end else if (!stall) begin
      if (ld_en) begin
        if_pc   <= ld_pc;
        if_insn <= ld_insn;
        if_en   <= 1'b1;
      end else begin
        // Bubble: if_pc keeps its last value, only the valid bit and opcode are meaningful.
        if_insn <= NOP;
        if_en   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, instruction-bus read FSM, 1-entry hold buffer, IF/ID register.
// Latency: 1 instruction/cycle with single-cycle rdy; IF/ID updates the edge the beat completes.
// Backpressure: Stall parks a completing beat in the hold buffer and suppresses new requests.
// Ports: clk, reset_ (sync, active-high), Stall, Flush/NewPC, BrTaken/BrAddr, ibus (master),
//        Busy, IFPC/IFInsn/IFEn; with IF_PERF_CNT_EN defined also FetchCnt/BubbleCnt.
module if_stage
  import cpu_pkg::*;
#(
  parameter int                     WORD_ADDR_W  = WORD_ADDR_W_DEF,
  parameter int                     WORD_DATA_W  = WORD_DATA_W_DEF,
  parameter logic [WORD_ADDR_W-1:0] RESET_VECTOR = WORD_ADDR_W'(RESET_VECTOR_DEF)
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic [WORD_ADDR_W-1:0] NewPC,
  input  logic                   BrTaken,
  input  logic [WORD_ADDR_W-1:0] BrAddr,
  if_stage_if.master             ibus,
  output logic                   Busy,
  output logic [WORD_ADDR_W-1:0] IFPC,
  output logic [WORD_DATA_W-1:0] IFInsn,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]            FetchCnt,
  output logic [31:0]            BubbleCnt,
`endif
  output logic                   IFEn
);

  localparam logic [WORD_DATA_W-1:0] NOP = WORD_DATA_W'(ISA_NOP);

  if_state_t              state;
  logic [WORD_ADDR_W-1:0] pc;
  logic [WORD_ADDR_W-1:0] pc_nxt;
  logic [WORD_DATA_W-1:0] hold_dat;
  logic                   bus_req;
  logic [WORD_ADDR_W-1:0] bus_addr;
  logic                   fetch_done;
  logic                   ld_en;
  logic                   deliver;
  logic [WORD_DATA_W-1:0] ld_dat;

  assign ibus.req  = bus_req;
  assign ibus.addr = bus_addr;
  assign Busy      = bus_req & ~ibus.rdy;

  // An instruction is available for IF/ID either straight off the bus or from the parked beat.
  assign fetch_done = (state == ST_FETCH) && ibus.rdy;
  assign ld_en      = fetch_done || (state == ST_HOLD);
  assign deliver    = ld_en && !Flush && !Stall;
  assign ld_dat     = (state == ST_HOLD) ? hold_dat : ibus.rd_data;

  // Branch wins over sequential advance, but the instruction delivered this cycle still goes
  // through (delay slot).
  assign pc_nxt = BrTaken ? BrAddr : (deliver ? pc + WORD_ADDR_W'(1) : pc);

  always_ff @(posedge clk) begin
    if (reset_) begin
      state    <= ST_IDLE;
      pc       <= RESET_VECTOR;
      hold_dat <= NOP;
      bus_req  <= 1'b0;
      bus_addr <= RESET_VECTOR;
    end else if (Flush) begin
      pc      <= NewPC;
      bus_req <= 1'b1;
      // A beat still in flight must be drained before the new address may go out; bus_addr
      // stays on the old address for the ST_KILL wait.
      if ((state == ST_FETCH || state == ST_KILL) && !ibus.rdy) begin
        state <= ST_KILL;
      end else begin
        state    <= ST_FETCH;
        bus_addr <= NewPC;
      end
    end else if (Stall) begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          bus_req  <= 1'b1;
          bus_addr <= pc;
        end
        ST_FETCH: if (ibus.rdy) begin
          state    <= ST_HOLD;
          bus_req  <= 1'b0;
          hold_dat <= ibus.rd_data;
        end
        ST_KILL: if (ibus.rdy) begin
          state    <= ST_FETCH;
          bus_addr <= pc;
        end
        default: ;
      endcase
    end else begin
      pc <= pc_nxt;
      case (state)
        ST_IDLE, ST_HOLD: begin
          state    <= ST_FETCH;
          bus_req  <= 1'b1;
          bus_addr <= pc_nxt;
        end
        ST_FETCH: begin
          if (ibus.rdy) begin
            bus_addr <= pc_nxt;
          end else if (BrTaken) begin
            // The pending beat belongs to the fall-through path; drain and drop it.
            state <= ST_KILL;
          end
        end
        ST_KILL: if (ibus.rdy) begin
          state    <= ST_FETCH;
          bus_addr <= pc_nxt;
        end
        default: ;
      endcase
    end
  end

  if_reg #(
    .WORD_ADDR_W (WORD_ADDR_W),
    .WORD_DATA_W (WORD_DATA_W)
  ) u_if_reg (
    .clk     (clk),
    .reset_  (reset_),
    .stall   (Stall),
    .flush   (Flush),
    .ld_en   (ld_en),
    .ld_pc   (pc),
    .ld_insn (ld_dat),
    .if_pc   (IFPC),
    .if_insn (IFInsn),
    .if_en   (IFEn)
  );

`ifdef IF_PERF_CNT_EN
  logic cnt_fetch;
  logic cnt_bubble;

  assign cnt_fetch  = deliver;
  assign cnt_bubble = Flush || (!Stall && !ld_en);

  always_ff @(posedge clk) begin
    if (reset_) begin
      FetchCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      if (cnt_fetch && (FetchCnt != 32'hFFFF_FFFF))   FetchCnt  <= FetchCnt + 32'd1;
      if (cnt_bubble && (BubbleCnt != 32'hFFFF_FFFF)) BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import cpu_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_;
  logic          Stall, Flush, BrTaken;
  logic [AW-1:0] NewPC, BrAddr;
  logic          Busy, IFEn;
  logic [AW-1:0] IFPC;
  logic [DW-1:0] IFInsn;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   FetchCnt, BubbleCnt;
`endif

  if_stage_if #(.WORD_ADDR_W(AW), .WORD_DATA_W(DW)) ibus ();

  if_stage #(.WORD_ADDR_W(AW), .WORD_DATA_W(DW), .RESET_VECTOR(30'h0)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .Stall     (Stall),
    .Flush     (Flush),
    .NewPC     (NewPC),
    .BrTaken   (BrTaken),
    .BrAddr    (BrAddr),
    .ibus      (ibus),
    .Busy      (Busy),
    .IFPC      (IFPC),
    .IFInsn    (IFInsn),
`ifdef IF_PERF_CNT_EN
    .FetchCnt  (FetchCnt),
    .BubbleCnt (BubbleCnt),
`endif
    .IFEn      (IFEn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] insn;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [AW-1:0] tail_pc;
  int            n_deliv = 0;
  int            tot_deliv = 0;
  int            tot_bubble = 0;
  int            busy_cnt = 0;
  bit            seen[logic [AW-1:0]];

  // Instruction memory contents: distinct word per address.
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {2'b10, a} ^ 32'h5A5A_1234;
  endfunction

  assign ibus.rd_data = mem(ibus.addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int   max_wait = 0;
  int   wait_left = 0;
  bit   fixed_wait = 1'b1;
  logic m_req = 1'b0, m_rdy = 1'b0;
  logic [AW-1:0] m_addr = '0;

  initial begin
    ibus.rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (ibus.req) begin
        seen[ibus.addr] = 1'b1;
        if (wait_left == 0) begin
          ibus.rdy  = 1'b1;
          wait_left = fixed_wait ? max_wait : int'($urandom_range(max_wait, 0));
        end else begin
          ibus.rdy  = 1'b0;
          wait_left--;
        end
      end else begin
        ibus.rdy = (max_wait == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      end
      m_req  = ibus.req;
      m_rdy  = ibus.rdy;
      m_addr = ibus.addr;
      #1;
      if (Busy) busy_cnt++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [AW-1:0] p_pc;
  logic [DW-1:0] p_insn;
  logic          p_en;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset_) begin
        tot_deliv  = 0;
        tot_bubble = 0;
      end else begin
        chk("busy", Busy, ibus.req & ~ibus.rdy);
        if (m_req && !m_rdy) begin
          chk("req_held", ibus.req, 1'b1);
          chk("addr_held", ibus.addr, m_addr);
        end
        if (!Flush && Stall) begin
          chk("stall_pc", IFPC, p_pc);
          chk("stall_insn", IFInsn, p_insn);
          chk("stall_en", IFEn, p_en);
        end else if (!Flush && IFEn) begin
          n_deliv++;
          tot_deliv++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_unexpected: got pc %0h, expected no delivery", IFPC);
          end else begin
            mon_e = exp_q.pop_front();
            chk("deliver_pc", IFPC, mon_e.pc);
            chk("deliver_insn", IFInsn, mon_e.insn);
          end
        end else begin
          tot_bubble++;
          chk("bubble_en", IFEn, 1'b0);
          chk("bubble_insn", IFInsn, ISA_NOP);
        end
      end
      p_pc   = IFPC;
      p_insn = IFInsn;
      p_en   = IFEn;
    end
  end

  // ---------------- reference model of program order ----------------
  task automatic redirect(input logic [AW-1:0] t);
    exp_q.delete();
    tail_pc = t;
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: tail_pc, insn: mem(tail_pc)});
      tail_pc = tail_pc + 30'd1;
    end
  endtask

  // One cycle: drive at negedge, then update the model after the edge has been monitored.
  task automatic step(input bit st, input bit fl, input logic [AW-1:0] npc,
                      input bit br, input logic [AW-1:0] baddr);
    @(negedge clk);
    Stall = st; Flush = fl; NewPC = npc; BrTaken = br; BrAddr = baddr;
    @(posedge clk); #2;
    if (fl)            redirect(npc);
    else if (!st && br) redirect(baddr);
    refill();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wait_addr(input string name, input logic [AW-1:0] a);
    int n = 0;
    while (!(ibus.req && ibus.addr == a) && n < 40) begin
      idle();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s: got no request for %0h, expected one within 40 cycles", name, a);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_ = 1'b1; Stall = 1'b0; Flush = 1'b0; BrTaken = 1'b0;
    NewPC = '0; BrAddr = '0; tail_pc = '0;

    // Reset, then sequential fetch with rdy tied high.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ifpc", IFPC, 30'h0);
    chk("rst_ifinsn", IFInsn, ISA_NOP);
    chk("rst_ifen", IFEn, 1'b0);
    chk("rst_busreq", ibus.req, 1'b0);
    chk("rst_busaddr", ibus.addr, 30'h0);
    chk("rst_busy", Busy, 1'b0);
    redirect(30'h0);
    refill();
    @(negedge clk); reset_ = 1'b0;
    @(posedge clk); #2;
    refill();
    chk("first_req", ibus.req, 1'b1);
    chk("first_addr", ibus.addr, 30'h0);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("seq_en", IFEn, 1'b1);
      chk("seq_pc", IFPC, 30'(k));
    end
    repeat (6) idle();

    // Two wait states per beat: one instruction every 3 cycles, Busy 2 of every 3.
    fixed_wait = 1'b1; max_wait = 2;
    step(1'b0, 1'b1, 30'h20, 1'b0, '0);
    wait_left = 2;
    n_deliv = 0; busy_cnt = 0;
    repeat (30) idle();
    chk("wait_deliveries", n_deliv, 10);
    chk("wait_busy_cycles", busy_cnt, 20);

    // Branch in the delay slot: PC 5 delivered, then 0x100, address 6 never requested.
    max_wait = 0; wait_left = 0;
    step(1'b0, 1'b1, 30'h2, 1'b0, '0);
    seen.delete();
    wait_addr("br_reach5", 30'h5);
    step(1'b0, 1'b0, '0, 1'b1, 30'h100);
    chk("br_slot_pc", IFPC, 30'h5);
    chk("br_slot_en", IFEn, 1'b1);
    chk("br_next_addr", ibus.addr, 30'h100);
    repeat (5) idle();
    chk("br_no_addr6", seen.exists(30'h6), 1'b0);

    // Flush while the beat at 8 is still waiting: beat drained and dropped, then 0x40.
    max_wait = 5; wait_left = 0;
    step(1'b0, 1'b1, 30'h8, 1'b0, '0);
    wait_left = 5;
    wait_addr("fl_reach8", 30'h8);
    idle();
    step(1'b0, 1'b1, 30'h40, 1'b0, '0);
    chk("fl_kill_req", ibus.req, 1'b1);
    chk("fl_kill_addr", ibus.addr, 30'h8);
    chk("fl_ifen", IFEn, 1'b0);
    wait_addr("fl_reach40", 30'h40);
    chk("fl_drop_en", IFEn, 1'b0);
    max_wait = 0;
    repeat (8) idle();

    // Stall while beat 3 completes: parked, no request; released -> 3 delivered, then 4.
    wait_left = 0;
    step(1'b0, 1'b1, 30'h0, 1'b0, '0);
    wait_addr("st_reach3", 30'h3);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, '0, 1'b0, '0);
      chk("st_busreq", ibus.req, 1'b0);
      chk("st_ifpc", IFPC, 30'h2);
    end
    idle();
    chk("st_rel_pc", IFPC, 30'h3);
    chk("st_rel_en", IFEn, 1'b1);
    chk("st_next_req", ibus.req, 1'b1);
    chk("st_next_addr", ibus.addr, 30'h4);

    // PC wrap.
    step(1'b0, 1'b1, 30'h3FFF_FFFE, 1'b0, '0);
    wait_addr("wrap_reach", 30'h3FFF_FFFF);
    idle();
    chk("wrap_addr", ibus.addr, 30'h0);
    repeat (4) idle();

    // Reset during a pending access: access abandoned, fetch restarts at the reset vector.
    fixed_wait = 1'b1; max_wait = 3; wait_left = 3;
    idle();
    @(negedge clk); reset_ = 1'b1;
    @(posedge clk); #2;
    chk("mrst_busreq", ibus.req, 1'b0);
    chk("mrst_busaddr", ibus.addr, 30'h0);
    chk("mrst_ifen", IFEn, 1'b0);
    max_wait = 0; wait_left = 0;
    redirect(30'h0);
    refill();
    @(negedge clk); reset_ = 1'b0;
    @(posedge clk); #2;
    refill();
    repeat (4) idle();
    chk("mrst_ifpc", IFPC, 30'h3);

    // Randomized traffic: waits, stalls, branches, flushes.
    fixed_wait = 1'b0; max_wait = 3;
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 4) == 0, ($urandom % 40) == 0, AW'($urandom),
           ($urandom % 12) == 0, AW'($urandom));
    end
    step(1'b0, 1'b0, '0, 1'b0, '0);

`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", FetchCnt, 32'(tot_deliv));
    chk("bubble_cnt", BubbleCnt, 32'(tot_bubble));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of stimulus, expected completion before 500000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
